uart_fifo_tx: RTL
=================

Name: uart_fifo_tx

Overview:
- UART transmitter that drains the echo service's byte FIFO: pops one word when the FIFO is non-empty and serialises it on `tx` as an 8N1-style frame.
- Sits between the FIFO read port (`re` / `dataOut` / `empty_flag`) and the board TX pin. It is the consumer end of the path whose producer is the UART receiver writing into the FIFO.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per bit period (25 MHz / 115200); must be ≥ 2.
- DATA_BITS, 8, payload bits per frame; equals the FIFO width.
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  FIFO `empty_flag`.
- fifo_data  input  DATA_BITS  FIFO `dataOut` (word at read pointer).
- fifo_re  output  1  FIFO read enable; one-cycle pop strobe.
- tx_enable  input  1  flow control; low = do not start a new frame.
- tx  output  1  serial line, idle high, registered.
- busy  output  1  high from LOAD until the frame is complete.
- frame_done  output  1  one-cycle pulse when the stop bit(s) finish.

Behaviour:
- Reset (async assert, sync release): state=IDLE, tx=1, fifo_re=0, busy=0, frame_done=0, counters=0, shift register=0.
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If fifo_empty==0 && tx_enable==1 → LOAD.
- LOAD (exactly 1 cycle):
  - fifo_re=1 this cycle only; shift register <= fifo_data this same cycle.
  - Data validity: fifo_data is sampled only after fifo_empty has been low for ≥1 full cycle in IDLE, so both registered-read and fall-through RAMs present the correct word.
  - → START.
- START:
  - tx<=0 on the edge entering START; held for CLKS_PER_BIT cycles.
  - → DATA.
- DATA:
  - DATA_BITS bits, LSB first, each held CLKS_PER_BIT cycles.
  - Bit index counts 0..DATA_BITS-1; the shift register shifts right at each bit boundary.
  - After the last bit → STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - frame_done=1 on the cycle following the final stop cycle; → IDLE.
- Frame length: (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles of tx; 40 with defaults and CLKS_PER_BIT=4.
- Back-to-back: minimum 2 idle-high cycles (IDLE + LOAD) between consecutive frames.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary; cleared on entering START.
- tx_enable:
  - Sampled only in IDLE.
  - Deassertion mid-frame does not truncate or stretch the frame.
- fifo_re:
  - Never asserted while fifo_empty==1.
  - Never asserted for more than 1 cycle per frame.
  - Exactly one pop per frame.
- fifo_empty changes after LOAD are ignored until the return to IDLE.
- Reset mid-frame: tx returns high immediately (async); the frame is abandoned and the popped word is lost; no fifo_re is issued during reset.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a parity bit is inserted between DATA and STOP (state PARITY, CLKS_PER_BIT cycles).
  - Even parity: the parity bit is the XOR of the data bits.
  - Frame length grows by CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic; frame as described above.

Decomposition:
- Shared include uart_defs.vh holds:
  - State encodings (3-bit localparams IDLE=0, LOAD=1, START=2, DATA=3, STOP=4, PARITY=5).
  - Default CLKS_PER_BIT.
  - The $clog2-based counter-width helper.
  - The UART receiver uses the same file.
- Sub-module uart_baud_counter (parameter CLKS_PER_BIT; inputs clk, rst_n, clear; output tick at count==CLKS_PER_BIT-1).
  - Reused by the receiver with half-bit preload.

Test Plan (CLKS_PER_BIT=4):
- Reset then idle with fifo_empty=1 for 100 cycles → tx=1, fifo_re=0, busy=0 throughout.
- Single word 0xA5 → one fifo_re pulse; tx bits 0,1,0,1,0,0,1,0,1,1 each 4 cycles; frame_done pulse 1 cycle after the 40th tx cycle.
- Two words 0x00 then 0xFF back-to-back → exactly 2 fifo_re pulses; 2 idle-high cycles between the stop of frame 1 and the start of frame 2; payload bits all 0 then all 1.
- tx_enable=0 with a non-empty FIFO → no fifo_re, tx=1. Raise tx_enable → LOAD next cycle. Drop tx_enable at DATA bit 3 → frame completes unchanged.
- rst_n asserted at DATA bit 4 of 0x3C → tx=1 within the same cycle, state IDLE. After release the next FIFO word is sent intact; 0x3C is not resent.
- With UART_TX_PARITY_EN defined, send 0x07 → parity bit 1 (three ones) after the data bits; frame is 44 cycles.

Source files
------------

// File: rtl/uart_fifo_tx_pkg.sv
// Shared UART definitions: state encodings, default bit period and the counter-width helper.
// Imported by the transmitter, its baud counter and the matching receiver.
package uart_fifo_tx_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 217;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    STOP   = 3'd4,
    PARITY = 3'd5
  } uart_state_e;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_fifo_tx_if.sv
// FIFO read port between the echo FIFO and the UART transmitter.
// master = consumer issuing the pop strobe, slave = FIFO presenting the word at the read pointer.
interface uart_fifo_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_re;

  modport master (input fifo_empty, input fifo_data, output fifo_re);
  modport slave  (output fifo_empty, output fifo_data, input fifo_re);
endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit with tick.
// Held at zero while clear is high so the first bit after clear gets a full period.
module uart_baud_counter
  import uart_fifo_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int           W    = cnt_width(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmitter draining the echo FIFO: pops one word per frame and sends it LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_fifo_tx
  import uart_fifo_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_fifo_tx_if.master fifo,
  input  logic           tx_enable,
  output logic           tx,
  output logic           busy,
  output logic           frame_done
);

  localparam int               BIT_W     = cnt_width(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  uart_state_e          state, state_nx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic [BIT_W-1:0]     bit_idx, bit_nx;
  logic                 tx_nx, done_nx, tick;

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear ((state == IDLE) || (state == LOAD)),
    .tick  (tick)
  );

`ifdef UART_TX_PARITY_EN
  logic parity, parity_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity <= 1'b0;
    else        parity <= parity_nx;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      shift      <= '0;
      bit_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      tx         <= tx_nx;
      shift      <= shift_nx;
      bit_idx    <= bit_nx;
      frame_done <= done_nx;
    end
  end

  // IDLE wait | LOAD pop+capture | START line low | DATA lsb first | PARITY even | STOP line high
  always_comb begin
    state_nx = state;
    tx_nx    = tx;
    shift_nx = shift;
    bit_nx   = bit_idx;
    done_nx  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_nx = parity;
`endif
    case (state)
      IDLE: begin
        tx_nx = 1'b1;
        if (!fifo.fifo_empty && tx_enable) state_nx = LOAD;
      end
      LOAD: begin
        shift_nx = fifo.fifo_data;
        bit_nx   = '0;
        tx_nx    = 1'b0;
        state_nx = START;
`ifdef UART_TX_PARITY_EN
        parity_nx = ^fifo.fifo_data;
`endif
      end
      START: begin
        if (tick) begin
          tx_nx    = shift[0];
          state_nx = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_nx = shift >> 1;
          if (bit_idx == LAST_BIT) begin
            bit_nx = '0;
`ifdef UART_TX_PARITY_EN
            tx_nx    = parity;
            state_nx = PARITY;
`else
            tx_nx    = 1'b1;
            state_nx = STOP;
`endif
          end else begin
            bit_nx = bit_idx + BIT_W'(1);
            tx_nx  = shift_nx[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          tx_nx    = 1'b1;
          state_nx = STOP;
        end
      end
`endif
      STOP: begin
        tx_nx = 1'b1;
        if (tick) begin
          if (bit_idx == LAST_STOP) begin
            bit_nx   = '0;
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            bit_nx = bit_idx + BIT_W'(1);
          end
        end
      end
      default: begin
        tx_nx    = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  assign fifo.fifo_re = (state == LOAD);
  assign busy         = (state != IDLE);

endmodule
